execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 One clock; reset is synchronous and active-high. All ports below are fixed.
REQ-002 clk  in  1  rising-edge clock
REQ-003 rst  in  1  synchronous active-high reset
REQ-004 in_valid / in_ready  in / out  1 / 1  decode-side handshake
REQ-005 in_icode, in_ifun  in  4, 4  Y86 instruction code and function code
REQ-006 in_valA, in_valB, in_valC  in  64 each  register operands and immediate
REQ-007 in_dstE  in  4  destination register (0xF = RNONE)
REQ-008 cc_inhibit  in  1  downstream exception; blocks the CC write this cycle
REQ-009 out_valid / out_ready  out / in  1 / 1  memory-side handshake
REQ-010 out_valE  out  64  ALU result
REQ-011 out_cnd  out  1  condition result
REQ-012 out_dstE, out_icode  out  4, 4  forwarded
REQ-013 out_stat  out  3  1 AOK, 2 HLT, 4 INS
REQ-014 cc_zf, cc_sf, cc_of  out  1 each  architectural condition codes

Function
REQ-015 Handshake: in_ready = (state==RUN) && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready. Latency is 1 cycle.
REQ-016 Output regs hold while out_valid && !out_ready. out_valid clears on an out_ready cycle that has no new transfer.
REQ-017 aluA source: valA for RRMOVQ(2)/OPQ(6). valC for IRMOVQ(3)/RMMOVQ(4)/MRMOVQ(5). -8 for CALL(8)/PUSH(A). +8 for RET(9)/POP(B). Otherwise 0.
REQ-018 aluB source: valB for 4,5,6,8,9,A,B. 0 for 2,3. Otherwise 0.
REQ-019 Operation: ifun[1:0] for OPQ (0 add, 1 sub, 2 and, 3 xor); add for all other icodes.
REQ-020 Result: valE = aluB op aluA, mod 2^64. The sub case is valB-valA.
REQ-021 CC update occurs only on an accepted OPQ with cc_inhibit=0.
  - ZF = (valE==0).
  - SF = valE[63].
  - OF, add: sign(aluA)==sign(aluB) && sign(valE)!=sign(aluA).
  - OF, sub: sign(aluA)!=sign(aluB) && sign(valE)!=sign(aluB).
  - OF, and/xor: 0.
REQ-022 out_cnd for JXX(7)/RRMOVQ(2) uses current CC, per ifun:
  - 0: 1
  - 1: (SF^OF)|ZF
  - 2: SF^OF
  - 3: ZF
  - 4: !ZF
  - 5: !(SF^OF)
  - 6: !(SF^OF)&&!ZF
  - ifun>6: INS
  - For other icodes out_cnd=0.
REQ-023 RRMOVQ with cnd=0 SHALL output out_dstE=0xF.
REQ-024 FSM RUN->HALT on acceptance of HALT(0) or an invalid icode (>0xB, or ifun out of range).
  - HALT gives out_stat=2; invalid gives out_stat=4.
  - In HALT: in_ready=0, CC frozen, last output held until consumed.
  - HALT is left only by rst.
REQ-025 NOP(1) passes through with valE=0 and stat AOK.
REQ-026 If cc_inhibit is asserted in the same cycle as an OPQ transfer, valE is still produced and only the CC write is suppressed.

Reset
REQ-027 rst in any state (including mid-stall) SHALL set:
  - state=RUN, out_valid=0
  - out_valE=0, out_cnd=0, out_dstE=0xF, out_icode=1, out_stat=1
  - ZF=1, SF=0, OF=0
  - perf counters=0
REQ-028 A pending output is discarded at rst.

Configuration
REQ-029 Macro EXEC_PERF_EN.
  - Defined: adds outputs perf_insn_cnt[31:0] and perf_stall_cnt[31:0]. perf_insn_cnt increments per transfer; perf_stall_cnt increments per cycle with out_valid && !out_ready. Both wrap at 2^32.
  - Undefined: ports and logic are absent; all other behaviour is identical.

Structure
REQ-030 Package y86_pkg holds: icode/ifun constants, stat codes, ALU op codes (ADD=0, SUB=1, AND=2, XOR=3), and RNONE.
REQ-031 The existing four-function 64-bit ALU SHALL be instantiated with A=aluB and B=aluA.
REQ-032 One sub-module, cond_eval (ifun, ZF, SF, OF -> cnd, valid), is combinational.

Verification
REQ-033 OPQ sub: valA=5, valB=3 -> valE=0xFFFF_FFFF_FFFF_FFFE, SF=1, ZF=0, OF=0; next JXX ifun=2 -> cnd=1.
REQ-034 OPQ add: valA=valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, OF=1; same op with cc_inhibit=1 -> CC unchanged.
REQ-035 PUSH: valB=0x100 -> valE=0xF8. POP: valB=0xF8 -> valE=0x100. IRMOVQ: valC=0x1234 -> valE=0x1234.
REQ-036 out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, perf_stall_cnt=3 (EXEC_PERF_EN); release -> next instruction accepted.
REQ-037 HALT accepted -> out_stat=2, in_ready=0 thereafter; icode 0xC -> out_stat=4; rst -> in_ready=1, out_valid=0, ZF=1.
REQ-038 CMOVLE after an OPQ giving ZF=0, SF=0 -> cnd=0, out_dstE=0xF.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the execute stage: instruction/function codes, status codes,
// ALU opcodes, the "no register" id and an ifun range check for the non-conditional icodes.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  localparam logic [3:0] F_OPQ_MAX  = 4'h3;
  localparam logic [3:0] F_COND_MAX = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  // Conditional icodes (RRMOVQ/JXX) are range-checked by cond_eval, so they pass here.
  function automatic logic ifun_ok(input logic [3:0] icode, input logic [3:0] ifun);
    case (icode)
      I_OPQ:            ifun_ok = (ifun <= F_OPQ_MAX);
      I_RRMOVQ, I_JXX:  ifun_ok = 1'b1;
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_CALL, I_RET, I_PUSH, I_POP: ifun_ok = (ifun == 4'h0);
      default:          ifun_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Four-function 64-bit ALU, purely combinational: y = a op b (sub is a - b).
// No state, no handshake; the caller decides operand order.
module alu
  import y86_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_op_t     op,
  output logic [63:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/cond_eval.sv
// Combinational Y86 branch/cmov condition from ifun and the current flags.
// Zero latency; valid drops for ifun codes that name no condition.
module cond_eval (
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd,
  output logic       valid
);

  always_comb begin
    cnd   = 1'b0;
    valid = 1'b1;
    case (ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf ^ of) | zf;
      4'h2:    cnd = sf ^ of;
      4'h3:    cnd = zf;
      4'h4:    cnd = !zf;
      4'h5:    cnd = !(sf ^ of);
      4'h6:    cnd = !(sf ^ of) && !zf;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86 execute stage: ALU, condition codes and cnd, one register stage (latency 1); stalls
// upstream while a result waits on out_ready, stops after HALT/INS. EXEC_PERF_EN adds counters.
module execute_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_ifun,
  input  logic [63:0] in_valA,
  input  logic [63:0] in_valB,
  input  logic [63:0] in_valC,
  input  logic [3:0]  in_dstE,
  input  logic        cc_inhibit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_valE,
  output logic        out_cnd,
  output logic [3:0]  out_dstE,
  output logic [3:0]  out_icode,
  output logic [2:0]  out_stat,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
`ifdef EXEC_PERF_EN
  ,
  output logic [31:0] perf_insn_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state, state_next;
  logic        xfer;
  logic [63:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op;
  logic        of_new;
  logic        cond_cnd, cond_valid;
  logic        is_cond_icode, cnd, invalid, stop, cc_we;
  stat_t       stat_next;
  logic [3:0]  dst_next;

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (in_icode)
      I_RRMOVQ: alu_a = in_valA;
      I_OPQ: begin
        alu_a = in_valA;
        alu_b = in_valB;
      end
      I_IRMOVQ: alu_a = in_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = in_valC;
        alu_b = in_valB;
      end
      I_CALL, I_PUSH: begin
        alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
        alu_b = in_valB;
      end
      I_RET, I_POP: begin
        alu_a = 64'd8;
        alu_b = in_valB;
      end
      default: ;
    endcase
  end

  assign alu_op = (in_icode == I_OPQ) ? alu_op_t'(in_ifun[1:0]) : ALU_ADD;

  // Operand order makes the subtract come out as valB - valA.
  alu u_alu (
    .a  (alu_b),
    .b  (alu_a),
    .op (alu_op),
    .y  (alu_y)
  );

  always_comb begin
    of_new = 1'b0;
    case (alu_op)
      ALU_ADD: of_new = (alu_a[63] == alu_b[63]) && (alu_y[63] != alu_a[63]);
      ALU_SUB: of_new = (alu_a[63] != alu_b[63]) && (alu_y[63] != alu_b[63]);
      default: of_new = 1'b0;
    endcase
  end

  cond_eval u_cond (
    .ifun  (in_ifun),
    .zf    (cc_zf),
    .sf    (cc_sf),
    .of    (cc_of),
    .cnd   (cond_cnd),
    .valid (cond_valid)
  );

  assign is_cond_icode = (in_icode == I_JXX) || (in_icode == I_RRMOVQ);
  assign cnd           = is_cond_icode && cond_cnd;
  assign invalid       = is_cond_icode ? !cond_valid : !ifun_ok(in_icode, in_ifun);
  assign stop          = invalid || (in_icode == I_HALT);
  assign stat_next     = invalid ? STAT_INS : ((in_icode == I_HALT) ? STAT_HLT : STAT_AOK);
  assign dst_next      = ((in_icode == I_RRMOVQ) && !cnd) ? RNONE : in_dstE;
  assign cc_we         = xfer && (in_icode == I_OPQ) && !invalid && !cc_inhibit;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (xfer && stop) state_next = S_HALT;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_valE  <= '0;
      out_cnd   <= 1'b0;
      out_dstE  <= RNONE;
      out_icode <= I_NOP;
      out_stat  <= STAT_AOK;
      cc_zf     <= 1'b1;
      cc_sf     <= 1'b0;
      cc_of     <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_valE  <= alu_y;
        out_cnd   <= cnd;
        out_dstE  <= dst_next;
        out_icode <= in_icode;
        out_stat  <= stat_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (cc_we) begin
        cc_zf <= (alu_y == 64'd0);
        cc_sf <= alu_y[63];
        cc_of <= of_new;
      end
    end
  end

`ifdef EXEC_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_insn_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (xfer)                    perf_insn_cnt  <= perf_insn_cnt + 32'd1;
      if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboarded bench for execute_stage: directed corner cases, then random traffic with
// random backpressure, every accepted instruction predicted by an arithmetic reference model.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_icode, in_ifun, in_dstE;
  logic [63:0] in_valA, in_valB, in_valC;
  logic        cc_inhibit;
  logic        out_valid, out_ready;
  logic [63:0] out_valE;
  logic        out_cnd;
  logic [3:0]  out_dstE, out_icode;
  logic [2:0]  out_stat;
  logic        cc_zf, cc_sf, cc_of;
`ifdef EXEC_PERF_EN
  logic [31:0] perf_insn_cnt, perf_stall_cnt;
`endif

  execute_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_icode   (in_icode),
    .in_ifun    (in_ifun),
    .in_valA    (in_valA),
    .in_valB    (in_valB),
    .in_valC    (in_valC),
    .in_dstE    (in_dstE),
    .cc_inhibit (cc_inhibit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_valE   (out_valE),
    .out_cnd    (out_cnd),
    .out_dstE   (out_dstE),
    .out_icode  (out_icode),
    .out_stat   (out_stat),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of)
`ifdef EXEC_PERF_EN
    ,
    .perf_insn_cnt  (perf_insn_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] vale;
    logic        cnd;
    logic [3:0]  dste;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic        zf, sf, of;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "global timeout");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: instruction semantics in plain arithmetic, flags from 65-bit signed math.
  function automatic void predict(input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] c, input logic [3:0] d, input logic inh);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] v;
    logic        bad, cond, nof;
    v    = '0;
    nof  = 1'b0;
    cond = 1'b0;
    full = '0;
    bad  = (ic > 4'hB) || (ic == 4'h6 && fn > 4'h3) ||
           ((ic == 4'h2 || ic == 4'h7) && fn > 4'h6) ||
           (ic != 4'h2 && ic != 4'h6 && ic != 4'h7 && fn != 4'h0);
    case (ic)
      4'h2: v = a;
      4'h3: v = c;
      4'h4, 4'h5: v = b + c;
      4'h6: begin
        case (fn[1:0])
          2'd0: begin full = {b[63], b} + {a[63], a}; v = full[63:0]; nof = full[64] ^ full[63]; end
          2'd1: begin full = {b[63], b} - {a[63], a}; v = full[63:0]; nof = full[64] ^ full[63]; end
          2'd2: v = b & a;
          default: v = b ^ a;
        endcase
      end
      4'h8, 4'hA: v = b - 64'd8;
      4'h9, 4'hB: v = b + 64'd8;
      default: v = '0;
    endcase
    if (ic == 4'h2 || ic == 4'h7) begin
      case (fn)
        4'h0: cond = 1'b1;
        4'h1: cond = (m_sf ^ m_of) | m_zf;
        4'h2: cond = m_sf ^ m_of;
        4'h3: cond = m_zf;
        4'h4: cond = !m_zf;
        4'h5: cond = !(m_sf ^ m_of);
        4'h6: cond = !(m_sf ^ m_of) && !m_zf;
        default: cond = 1'b0;
      endcase
    end
    if (ic == 4'h6 && !bad && !inh) begin
      m_zf = (v == 64'd0);
      m_sf = v[63];
      m_of = nof;
    end
    e.vale  = v;
    e.cnd   = cond;
    e.dste  = (ic == 4'h2 && !cond) ? 4'hF : d;
    e.icode = ic;
    e.stat  = bad ? 3'd4 : ((ic == 4'h0) ? 3'd2 : 3'd1);
    e.zf    = m_zf;
    e.sf    = m_sf;
    e.of    = m_of;
    q.push_back(e);
  endfunction

  // Monitor: whenever an output is presented it must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: out_valid=1 with icode 0x%0h, expected no output", out_icode);
        end else begin
          e = q[0];
          chk("out_valE",  out_valE,  e.vale);
          chk("out_cnd",   out_cnd,   e.cnd);
          chk("out_dstE",  out_dstE,  e.dste);
          chk("out_icode", out_icode, e.icode);
          chk("out_stat",  out_stat,  e.stat);
          chk("cc_zf",     cc_zf,     e.zf);
          chk("cc_sf",     cc_sf,     e.sf);
          chk("cc_of",     cc_of,     e.of);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] d,
                       input logic inh);
    in_icode   = ic;
    in_ifun    = fn;
    in_valA    = a;
    in_valB    = b;
    in_valC    = c;
    in_dstE    = d;
    cc_inhibit = inh;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] d,
                       input logic inh);
    bit done;
    done = 0;
    @(negedge clk);
    drive(ic, fn, a, b, c, d, inh);
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) begin
        predict(ic, fn, a, b, c, d, inh);
        done = 1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready=%0d after 100 cycles, expected 1", in_ready);
    end
  endtask

  // Issue one instruction and return while its result is on the outputs.
  task automatic run1(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic [3:0] d,
                      input logic inh);
    issue(ic, fn, a, b, c, d, inh);
    @(negedge clk);
    in_valid   = 1'b0;
    cc_inhibit = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    q.delete();
    m_zf = 1'b1;
    m_sf = 1'b0;
    m_of = 1'b0;
    rst  = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valE",  out_valE,  0);
    chk("rst_out_cnd",   out_cnd,   0);
    chk("rst_out_dstE",  out_dstE,  4'hF);
    chk("rst_out_icode", out_icode, 4'h1);
    chk("rst_out_stat",  out_stat,  3'd1);
    chk("rst_zf", cc_zf, 1);
    chk("rst_sf", cc_sf, 0);
    chk("rst_of", cc_of, 0);
`ifdef EXEC_PERF_EN
    chk("rst_perf_insn",  perf_insn_cnt,  0);
    chk("rst_perf_stall", perf_stall_cnt, 0);
`endif
  endtask

  initial begin
    logic [3:0]  ic, fn;
    logic [63:0] a, b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
    repeat (2) @(negedge clk);
    do_reset();
    out_ready = 1'b1;

    // sub giving -2, then a signed-less-than jump on the resulting flags
    run1(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h3, 1'b0);
    chk("sub_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_sf", cc_sf, 1);
    chk("sub_zf", cc_zf, 0);
    chk("sub_of", cc_of, 0);
    run1(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 1'b0);
    chk("jl_cnd", out_cnd, 1);

    run1(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 1'b0);
    chk("add_ovf_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_ovf_of", cc_of, 1);
    run1(4'h6, 4'h3, 64'd1, 64'd1, 64'd0, 4'h2, 1'b0);
    chk("xor_zf", cc_zf, 1);
    run1(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 1'b1);
    chk("inhibit_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("inhibit_zf", cc_zf, 1);
    chk("inhibit_of", cc_of, 0);

    run1(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 1'b0);
    chk("push_valE", out_valE, 64'hF8);
    run1(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 4'h4, 1'b0);
    chk("pop_valE", out_valE, 64'h100);
    run1(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h1, 1'b0);
    chk("irmovq_valE", out_valE, 64'h1234);
    run1(4'h1, 4'h0, 64'd9, 64'd9, 64'd9, 4'hF, 1'b0);
    chk("nop_valE", out_valE, 0);

    run1(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h0, 1'b0);
    run1(4'h2, 4'h1, 64'hAA, 64'd0, 64'd0, 4'h5, 1'b0);
    chk("cmovle_cnd", out_cnd, 0);
    chk("cmovle_dstE", out_dstE, 4'hF);

    // three cycles of downstream backpressure with a second instruction waiting
    do_reset();
    out_ready = 1'b1;
    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'hABC, 4'h1, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEF, 4'h2, 1'b0);
    repeat (3) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valE_held", out_valE, 64'hABC);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
`ifdef EXEC_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 3);
`endif
    chk("release_in_ready", in_ready, 1);
    predict(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEF, 4'h2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("release_valE", out_valE, 64'hDEF);
`ifdef EXEC_PERF_EN
    chk("perf_insn_cnt", perf_insn_cnt, 2);
`endif

    // HALT held unconsumed, then reset while it is still pending
    do_reset();
    out_ready = 1'b0;
    issue(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
    @(negedge clk);
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
    repeat (3) begin
      #1;
      chk("halt_in_ready", in_ready, 0);
      chk("halt_out_valid", out_valid, 1);
      chk("halt_stat", out_stat, 3'd2);
      @(negedge clk);
    end
    do_reset();
    out_ready = 1'b1;
    run1(4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 4'h3, 1'b0);
    chk("ins_stat", out_stat, 3'd4);
    @(negedge clk);
    #1;
    chk("ins_in_ready", in_ready, 0);

    // random traffic with random backpressure
    do_reset();
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      ic = 4'($urandom_range(1, 11));
      case (ic)
        4'h6:       fn = 4'($urandom_range(0, 3));
        4'h2, 4'h7: fn = 4'($urandom_range(0, 6));
        default:    fn = 4'h0;
      endcase
      case ($urandom_range(0, 3))
        0:       begin a = 64'($urandom_range(0, 3)); b = 64'($urandom_range(0, 3)); end
        1:       begin a = {1'b0, {63{1'b1}}} - 64'($urandom_range(0, 2)); b = {$urandom(), $urandom()}; end
        default: begin a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; end
      endcase
      drive(ic, fn, a, b, {$urandom(), $urandom()}, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready)
        predict(ic, fn, a, b, in_valC, in_dstE, cc_inhibit);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
